iob_spi_fl_arbiter: RTL and testbench
=====================================

# iob_spi_fl_arbiter

Serialises access to the single SPI flash master between two requesters: the software command path (CSR-driven FL_* registers) and the instruction/data cache read port. It latches the winner's address and command words, issues exactly one transaction to the flash controller, waits for completion (with a watchdog), and returns read data to the winner only. It sits between the CSR/cache interfaces and `spi_master_fl`, replacing the combinational cache/software mux.

## Interface
- ADDR_W, 24: flash address width.
- DATA_W, 32: read data width.
- CACHE_CMD, 32'h0008_200B: command word for cache reads.
  - Encoding: [7:0] 0x0B fast read, [14:8] 32 data bits, [19:16] 8 dummy cycles.
- CACHE_CMDTP, 32'h0000_0002: commtype word for cache reads.
- TIMEOUT_W, 16: watchdog counter width. Timeout fires at 2^TIMEOUT_W-1 cycles.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sw_valid  in  1  software request. Held until sw_ready.
- sw_address  in  ADDR_W  software address.
- sw_command  in  32  software command word.
- sw_commandtp  in  32  software commtype word.
- sw_ready  out  1  one-cycle completion pulse.
- sw_rdata  out  DATA_W  read data, valid with sw_ready.
- sw_err  out  1  timeout flag, valid with sw_ready.
- cache_valid  in  1  cache read request. Held until cache_ready.
- cache_address  in  ADDR_W  cache read address.
- cache_ready  out  1  one-cycle completion pulse.
- cache_rdata  out  DATA_W  read data, valid with cache_ready.
- cache_err  out  1  timeout flag, valid with cache_ready.
- fl_valid  out  1  one-cycle start pulse to the controller.
- fl_address  out  ADDR_W  latched address.
- fl_command  out  32  latched command word.
- fl_commandtp  out  32  latched commtype word.
- fl_rdata  in  DATA_W  controller read data.
- fl_done  in  1  one-cycle controller completion pulse.
- fl_abort  out  1  one-cycle pulse. The top level ORs it into the controller reset.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: sample sw_valid and cache_valid.
  - Only one valid: grant it.
  - Both valid: grant the requester not granted last time (round-robin).
  - After reset, last_grant = SW, so cache wins the first tie.
  - On grant: latch address, command and commtype into fl_* registers, record grant. Go to ISSUE.
  - Cache grant: command = CACHE_CMD, commtype = CACHE_CMDTP.
- ISSUE: fl_valid=1 for exactly this cycle. Clear watchdog. Go to WAIT.
- WAIT:
  - fl_done=1: latch fl_rdata into the response register, err=0, go to RESP.
  - Watchdog reaches all-ones first: err=1, response data=0, fl_abort=1 for one cycle, go to RESP.
  - fl_done and timeout in the same cycle: fl_done wins.
- RESP: pulse ready, with data and err, to the granted requester only. Update last_grant. Go to IDLE.
- fl_* outputs hold their values from grant until the next grant.
- fl_done outside WAIT is ignored, with no state change.
- A requester dropping valid mid-transaction is ignored. The transaction completes and ready still pulses.
- After ready, the requester drops valid or presents a new request. Valid still high in the IDLE cycle counts as a new request.

## Timing
- Reset values: all outputs 0, including fl_command and fl_commandtp. State=IDLE, last_grant=SW, watchdog=0.
- rst asserted in any state: next cycle is IDLE. An in-flight transaction is dropped with no ready pulse and no fl_abort.
- Valid seen at cycle N (IDLE) gives:
  - fl_valid at N+1.
  - Controller done at cycle D ≥ N+2 gives ready at D+1.
- Minimum request-to-ready latency is 3 cycles plus controller time.
- Back-to-back service: next grant is sampled at D+2. The gap between fl_valid pulses is at least 2 cycles after fl_done.
- Watchdog: increments every WAIT cycle and saturates. Timeout fires at 2^TIMEOUT_W-1 WAIT cycles after ISSUE.

## Structure
- Shared header iob_spi_fl.vh holds:
  - state encodings (2-bit);
  - GRANT_SW/GRANT_CACHE;
  - default CACHE_CMD and CACHE_CMDTP values;
  - command-word field offsets.
- Natural sub-module: iob_spi_fl_wdog, a clear/enable saturating counter with a terminal-count output.
- Arbitration and the FSM stay in the top module.

## Test plan
- Lone sw request: addr 0x000100, cmd 0x0000_2003 → fl_valid at N+1 with those values. Drive fl_done with fl_rdata=0xDEADBEEF → sw_ready one cycle later with rdata 0xDEADBEEF, err=0. cache_ready stays 0.
- Simultaneous sw+cache right after reset → cache granted first, fl_command=0x0008_200B. sw granted on the next IDLE. Ready order is cache then sw.
- Both held continuously for 6 transactions → grants strictly alternate; no starvation.
- TIMEOUT_W=4, fl_done never arrives → fl_abort pulse after 15 WAIT cycles. sw_err=1 and rdata=0 on ready. The next request is then served normally.
- rst asserted during WAIT → all outputs 0 next cycle and no ready pulse. A late fl_done while IDLE causes no response.
- fl_done and timeout in the same cycle → normal response, err=0, no fl_abort.

Source files
------------

// File: rtl/iob_spi_fl_arbiter_pkg.sv
// Shared types and constants for the SPI flash arbiter.
// Command-word field layout is kept here so cache defaults stay consistent.
package iob_spi_fl_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        GRANT_SW    = 1'b0,
        GRANT_CACHE = 1'b1
    } grant_t;

    localparam int CMD_OP_LSB    = 0;
    localparam int CMD_NBITS_LSB = 8;
    localparam int CMD_DUMMY_LSB = 16;

    function automatic logic [31:0] mk_cmd(
        input logic [7:0] op,
        input logic [6:0] nbits,
        input logic [3:0] dummy
    );
        logic [31:0] w;
        w = '0;
        w[CMD_OP_LSB +: 8]    = op;
        w[CMD_NBITS_LSB +: 7] = nbits;
        w[CMD_DUMMY_LSB +: 4] = dummy;
        return w;
    endfunction

    // Fast read, 32 data bits, 8 dummy cycles.
    localparam logic [31:0] CACHE_CMD_DEF   = mk_cmd(8'h0B, 7'd32, 4'd8);
    localparam logic [31:0] CACHE_CMDTP_DEF = 32'h0000_0002;

endpackage

// File: rtl/iob_spi_fl_arbiter_wdog.sv
// Clear/enable saturating counter; tc_o flags the enabled cycle in which
// the count reaches all-ones (and stays high while saturated).
module iob_spi_fl_arbiter_wdog #(
    parameter int W = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [W-1:0] MAX = '1;
    localparam logic [W-1:0] PEN = MAX - 1'b1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = en_i && ((cnt_q == PEN) || (cnt_q == MAX));

endmodule

// File: rtl/iob_spi_fl_arbiter.sv
// Round-robin arbiter between software and cache requesters for the single
// SPI flash controller, with a completion watchdog.
module iob_spi_fl_arbiter
    import iob_spi_fl_arbiter_pkg::*;
#(
    parameter int          ADDR_W      = 24,
    parameter int          DATA_W      = 32,
    parameter logic [31:0] CACHE_CMD   = CACHE_CMD_DEF,
    parameter logic [31:0] CACHE_CMDTP = CACHE_CMDTP_DEF,
    parameter int          TIMEOUT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sw_valid_i,
    input  logic [ADDR_W-1:0] sw_address_i,
    input  logic [31:0]       sw_command_i,
    input  logic [31:0]       sw_commandtp_i,
    output logic              sw_ready_o,
    output logic [DATA_W-1:0] sw_rdata_o,
    output logic              sw_err_o,
    input  logic              cache_valid_i,
    input  logic [ADDR_W-1:0] cache_address_i,
    output logic              cache_ready_o,
    output logic [DATA_W-1:0] cache_rdata_o,
    output logic              cache_err_o,
    output logic              fl_valid_o,
    output logic [ADDR_W-1:0] fl_address_o,
    output logic [31:0]       fl_command_o,
    output logic [31:0]       fl_commandtp_o,
    input  logic [DATA_W-1:0] fl_rdata_i,
    input  logic              fl_done_i,
    output logic              fl_abort_o
);

    state_t              state_q, state_d;
    grant_t              last_q, last_d;
    grant_t              grant_q, grant_d;
    grant_t              win;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         cmd_q, cmd_d;
    logic [31:0]         tp_q, tp_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                tc;

    iob_spi_fl_arbiter_wdog #(
        .W(TIMEOUT_W)
    ) u_wdog (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .clr_i(state_q == ST_ISSUE),
        .en_i (state_q == ST_WAIT),
        .tc_o (tc)
    );

    // On a tie the requester not served last time wins.
    always_comb begin
        if (sw_valid_i && cache_valid_i) begin
            win = (last_q == GRANT_SW) ? GRANT_CACHE : GRANT_SW;
        end else if (cache_valid_i) begin
            win = GRANT_CACHE;
        end else begin
            win = GRANT_SW;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            last_q  <= GRANT_SW;
            grant_q <= GRANT_SW;
            addr_q  <= '0;
            cmd_q   <= '0;
            tp_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            cmd_q   <= cmd_d;
            tp_q    <= tp_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        cmd_d   = cmd_q;
        tp_d    = tp_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (sw_valid_i || cache_valid_i) begin
                    grant_d = win;
                    state_d = ST_ISSUE;
                    if (win == GRANT_CACHE) begin
                        addr_d = cache_address_i;
                        cmd_d  = CACHE_CMD;
                        tp_d   = CACHE_CMDTP;
                    end else begin
                        addr_d = sw_address_i;
                        cmd_d  = sw_command_i;
                        tp_d   = sw_commandtp_i;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (fl_done_i) begin
                    rdata_d = fl_rdata_i;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (tc) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                last_d  = grant_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        sw_ready_o    = 1'b0;
        sw_rdata_o    = '0;
        sw_err_o      = 1'b0;
        cache_ready_o = 1'b0;
        cache_rdata_o = '0;
        cache_err_o   = 1'b0;
        fl_valid_o    = (state_q == ST_ISSUE);
        fl_abort_o    = 1'b0;
        if (state_q == ST_RESP) begin
            fl_abort_o = err_q;
            if (grant_q == GRANT_CACHE) begin
                cache_ready_o = 1'b1;
                cache_rdata_o = rdata_q;
                cache_err_o   = err_q;
            end else begin
                sw_ready_o = 1'b1;
                sw_rdata_o = rdata_q;
                sw_err_o   = err_q;
            end
        end
    end

    assign fl_address_o   = addr_q;
    assign fl_command_o   = cmd_q;
    assign fl_commandtp_o = tp_q;

endmodule

// File: tb/tb_iob_spi_fl_arbiter.sv
// Directed + randomized bench for iob_spi_fl_arbiter with a
// transaction-level round-robin reference model.
module tb_iob_spi_fl_arbiter;

    localparam int AW = 24;
    localparam int DW = 32;
    localparam logic [31:0] EXP_CACHE_CMD   = 32'h0008_200B;
    localparam logic [31:0] EXP_CACHE_CMDTP = 32'h0000_0002;

    logic          clk = 1'b0;
    logic          rst;
    logic          sw_valid;
    logic [AW-1:0] sw_address;
    logic [31:0]   sw_command;
    logic [31:0]   sw_commandtp;
    logic          sw_ready;
    logic [DW-1:0] sw_rdata;
    logic          sw_err;
    logic          cache_valid;
    logic [AW-1:0] cache_address;
    logic          cache_ready;
    logic [DW-1:0] cache_rdata;
    logic          cache_err;
    logic          fl_valid;
    logic [AW-1:0] fl_address;
    logic [31:0]   fl_command;
    logic [31:0]   fl_commandtp;
    logic [DW-1:0] fl_rdata;
    logic          fl_done;
    logic          fl_abort;

    int checks = 0;
    int errors = 0;
    bit last_cache;

    always #5 clk = ~clk;

    iob_spi_fl_arbiter #(
        .TIMEOUT_W(4)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .sw_valid_i     (sw_valid),
        .sw_address_i   (sw_address),
        .sw_command_i   (sw_command),
        .sw_commandtp_i (sw_commandtp),
        .sw_ready_o     (sw_ready),
        .sw_rdata_o     (sw_rdata),
        .sw_err_o       (sw_err),
        .cache_valid_i  (cache_valid),
        .cache_address_i(cache_address),
        .cache_ready_o  (cache_ready),
        .cache_rdata_o  (cache_rdata),
        .cache_err_o    (cache_err),
        .fl_valid_o     (fl_valid),
        .fl_address_o   (fl_address),
        .fl_command_o   (fl_command),
        .fl_commandtp_o (fl_commandtp),
        .fl_rdata_i     (fl_rdata),
        .fl_done_i      (fl_done),
        .fl_abort_o     (fl_abort)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_fl_valid"}, fl_valid, 0);
        chk({tag, "_fl_address"}, fl_address, 0);
        chk({tag, "_fl_command"}, fl_command, 0);
        chk({tag, "_fl_commandtp"}, fl_commandtp, 0);
        chk({tag, "_fl_abort"}, fl_abort, 0);
        chk({tag, "_readys"}, {sw_ready, cache_ready}, 0);
        chk({tag, "_rdata"}, {sw_rdata, cache_rdata}, 0);
        chk({tag, "_errs"}, {sw_err, cache_err}, 0);
    endtask

    task automatic rand_payload;
        sw_address    = AW'($urandom);
        sw_command    = $urandom;
        sw_commandtp  = $urandom;
        cache_address = AW'($urandom);
    endtask

    // Entered in an IDLE cycle with valids already presented.
    // delay = extra WAIT cycles before fl_done; to = controller never answers.
    task automatic serve(input int delay, input bit to, input logic [DW-1:0] data);
        bit            win_c;
        logic [AW-1:0] ea;
        logic [31:0]   ec;
        logic [31:0]   et;
        int            wc;
        win_c = (sw_valid && cache_valid) ? !last_cache : cache_valid;
        ea = win_c ? cache_address : sw_address;
        ec = win_c ? EXP_CACHE_CMD : sw_command;
        et = win_c ? EXP_CACHE_CMDTP : sw_commandtp;
        step;
        chk("fl_valid_pulse", fl_valid, 1);
        chk("fl_address", fl_address, ea);
        chk("fl_command", fl_command, ec);
        chk("fl_commandtp", fl_commandtp, et);
        step;
        chk("fl_valid_one_cycle", fl_valid, 0);
        if (!to) begin
            for (int i = 0; i < delay; i++) begin
                chk("no_early_ready", {sw_ready, cache_ready}, 0);
                step;
            end
            fl_rdata = data;
            fl_done  = 1'b1;
            step;
            fl_done  = 1'b0;
            fl_rdata = $urandom;
            chk("sw_ready", sw_ready, !win_c);
            chk("cache_ready", cache_ready, win_c);
            chk("rdata", win_c ? cache_rdata : sw_rdata, data);
            chk("err", {sw_err, cache_err}, 0);
            chk("no_abort", fl_abort, 0);
        end else begin
            wc = 1;
            while (!(sw_ready || cache_ready) && wc < 40) begin
                step;
                if (!(sw_ready || cache_ready)) wc++;
            end
            chk("timeout_wait_cycles", wc, 15);
            chk("to_sw_ready", sw_ready, !win_c);
            chk("to_cache_ready", cache_ready, win_c);
            chk("to_rdata", {sw_rdata, cache_rdata}, 0);
            chk("to_err", win_c ? cache_err : sw_err, 1);
            chk("to_abort", fl_abort, 1);
        end
        last_cache = win_c;
        step;
        chk("idle_no_ready", {sw_ready, cache_ready}, 0);
        chk("idle_abort_clear", fl_abort, 0);
        chk("fl_address_hold", fl_address, ea);
        chk("fl_command_hold", fl_command, ec);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        sw_valid     = 1'b0;
        cache_valid  = 1'b0;
        sw_address   = '0;
        sw_command   = '0;
        sw_commandtp = '0;
        cache_address = '0;
        fl_rdata     = '0;
        fl_done      = 1'b0;
        last_cache   = 1'b0;
        repeat (3) step;
        chk_all_zero("reset");
        rst = 1'b0;
        step;

        // Tie straight after reset: cache first, then sw.
        rand_payload();
        sw_valid    = 1'b1;
        cache_valid = 1'b1;
        serve(2, 1'b0, $urandom);
        chk("tie_first_cache", last_cache, 1);
        cache_valid = 1'b0;
        serve(1, 1'b0, $urandom);
        chk("tie_second_sw", last_cache, 0);

        // Lone sw request.
        sw_address   = 24'h000100;
        sw_command   = 32'h0000_2003;
        sw_commandtp = 32'h0000_0001;
        serve(0, 1'b0, 32'hDEAD_BEEF);

        // Both held: strict alternation.
        sw_valid    = 1'b1;
        cache_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bit prev;
            prev = last_cache;
            rand_payload();
            serve($urandom_range(0, 5), 1'b0, $urandom);
            chk("alternate", last_cache, !prev);
        end

        // Watchdog expiry, then normal service.
        cache_valid = 1'b0;
        rand_payload();
        serve(0, 1'b1, '0);
        sw_valid    = 1'b0;
        cache_valid = 1'b1;
        serve(3, 1'b0, $urandom);

        // fl_done in the timeout cycle wins.
        cache_valid = 1'b0;
        sw_valid    = 1'b1;
        rand_payload();
        serve(14, 1'b0, $urandom);

        // Reset during WAIT, then a stray fl_done while IDLE.
        rand_payload();
        step;
        chk("pre_rst_issue", fl_valid, 1);
        step;
        step;
        rst      = 1'b1;
        sw_valid = 1'b0;
        step;
        chk_all_zero("rst_wait");
        rst        = 1'b0;
        last_cache = 1'b0;
        fl_rdata   = $urandom;
        fl_done    = 1'b1;
        step;
        fl_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("late_done_ignored", {sw_ready, cache_ready, fl_valid}, 0);
            step;
        end

        // Tie again after reset.
        sw_valid    = 1'b1;
        cache_valid = 1'b1;
        rand_payload();
        serve(1, 1'b0, $urandom);
        chk("tie_after_rst_cache", last_cache, 1);

        // Random mix.
        for (int i = 0; i < 24; i++) begin
            sw_valid    = 1'($urandom_range(0, 1));
            cache_valid = 1'($urandom_range(0, 1));
            rand_payload();
            if (!sw_valid && !cache_valid) begin
                step;
                step;
                chk("idle_no_issue", fl_valid, 0);
            end else begin
                serve($urandom_range(0, 6), 1'b0, $urandom);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
